// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg: shared state encoding, default sizes and Q2 helpers.
// Used by the step, the iteration controller and its handshake interface.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam int WIDTH_DEF    = 10;
  localparam int ITER_W_DEF   = 8;
  localparam int MAX_ITER_DEF = 255;

  // 1.0 in Q2.(WIDTH_DEF-2)
  localparam int ONE = 1 << (WIDTH_DEF - 2);

  // 1.0 in Q2.(width-2) for any component width
  function automatic int q_one(int width);
    return 1 << (width - 2);
  endfunction

  function automatic logic is_pow2(logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/mandelbrot_if.sv
// mandelbrot_if: pixel-in / result-out valid-ready bundle.
// slave = iteration engine side, master = producer/consumer side.
interface mandelbrot_if
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ITER_W = ITER_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_cr;
  logic [WIDTH-1:0]  in_ci;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_iter;
  logic              out_escaped;
  logic              out_periodic;

  modport slave (
    input  in_valid,
    input  in_cr,
    input  in_ci,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_iter,
    output out_escaped,
    output out_periodic
  );

  modport master (
    output in_valid,
    output in_cr,
    output in_ci,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_iter,
    input  out_escaped,
    input  out_periodic
  );

endinterface

// File: rtl/mandelbrot.sv
// mandelbrot: combinational step z' = z^2 + c in Q2.(WIDTH-2).
// Ports: in_cr/in_ci/in_zr/in_zi -> out_zr/out_zi (wrapping), size = |z|^2 > 4.
module mandelbrot
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] in_cr,
  input  logic signed [WIDTH-1:0] in_ci,
  input  logic signed [WIDTH-1:0] in_zr,
  input  logic signed [WIDTH-1:0] in_zi,
  output logic signed [WIDTH-1:0] out_zr,
  output logic signed [WIDTH-1:0] out_zi,
  output logic                    size
);

  localparam int FRAC = WIDTH - 2;
  localparam int PW   = 2 * WIDTH;
  // 4.0 expressed in the squared (Q4.2*FRAC) domain
  localparam logic [PW:0] LIM =
    (PW+1)'(4 * q_one(WIDTH) * q_one(WIDTH));

  logic signed [PW-1:0] zr_x;
  logic signed [PW-1:0] zi_x;
  logic signed [PW-1:0] cr_x;
  logic signed [PW-1:0] ci_x;
  logic signed [PW-1:0] rr;
  logic signed [PW-1:0] ii;
  logic signed [PW-1:0] ri;
  logic        [PW:0]   mag;

  assign zr_x = {{WIDTH{in_zr[WIDTH-1]}}, in_zr};
  assign zi_x = {{WIDTH{in_zi[WIDTH-1]}}, in_zi};
  assign cr_x = {{WIDTH{in_cr[WIDTH-1]}}, in_cr};
  assign ci_x = {{WIDTH{in_ci[WIDTH-1]}}, in_ci};

  assign rr = zr_x * zr_x;
  assign ii = zi_x * zi_x;
  assign ri = zr_x * zi_x;

  // squares are non-negative; extra bit keeps the sum from overflowing
  assign mag  = {1'b0, rr} + {1'b0, ii};
  assign size = mag > LIM;

  assign out_zr = WIDTH'(((rr - ii) >>> FRAC) + cr_x);
  // 2*zr*zi >>> FRAC folded into one shift so 2*ri cannot overflow
  assign out_zi = WIDTH'((ri >>> (FRAC - 1)) + ci_x);

endmodule

// File: rtl/mandelbrot_iter_ctrl.sv
// mandelbrot_iter_ctrl: iterates the step per pixel, returns count/escape.
// Ports: clk, rst_n (async low), abort (sync flush), bus (mandelbrot_if.slave).
// Optional MANDEL_PERIOD_CHECK_EN: Brent snapshot exit drives out_periodic.
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ITER_W   = ITER_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  mandelbrot_if.slave bus
);

  typedef logic signed [WIDTH-1:0] q_t;

  localparam logic [ITER_W:0]   MAX_C = (ITER_W+1)'(MAX_ITER);
  localparam logic [ITER_W-1:0] MAX_O = ITER_W'(MAX_ITER);

  state_t state;
  state_t state_nxt;

  q_t cr;
  q_t ci;
  q_t zr;
  q_t zi;
  q_t cr_nxt;
  q_t ci_nxt;
  q_t zr_nxt;
  q_t zi_nxt;
  q_t step_zr;
  q_t step_zi;
  logic size;

  logic [ITER_W-1:0] cnt;
  logic [ITER_W-1:0] cnt_nxt;
  logic [ITER_W:0]   cnt_inc;
  logic              last;

  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_nxt;
  logic              esc_q;
  logic              esc_nxt;

`ifdef MANDEL_PERIOD_CHECK_EN
  q_t   sr;
  q_t   si;
  q_t   sr_nxt;
  q_t   si_nxt;
  logic sv;
  logic sv_nxt;
  logic per_q;
  logic per_nxt;
  logic per_hit;
  logic snap;
`endif

  mandelbrot #(
    .WIDTH(WIDTH)
  ) u_step (
    .in_cr (cr),
    .in_ci (ci),
    .in_zr (zr),
    .in_zi (zi),
    .out_zr(step_zr),
    .out_zi(step_zi),
    .size  (size)
  );

  // one spare bit: cnt+1 is compared before it could wrap
  assign cnt_inc = {1'b0, cnt} + (ITER_W+1)'(1);
  assign last    = cnt_inc == MAX_C;

`ifdef MANDEL_PERIOD_CHECK_EN
  assign snap    = is_pow2(32'(cnt_inc));
  assign per_hit = sv && (step_zr == sr) && (step_zi == si);
`endif

  always_comb begin
    state_nxt = state;
    cr_nxt    = cr;
    ci_nxt    = ci;
    zr_nxt    = zr;
    zi_nxt    = zi;
    cnt_nxt   = cnt;
    iter_nxt  = iter_q;
    esc_nxt   = esc_q;
`ifdef MANDEL_PERIOD_CHECK_EN
    sr_nxt    = sr;
    si_nxt    = si;
    sv_nxt    = sv;
    per_nxt   = per_q;
`endif

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          cr_nxt    = q_t'(bus.in_cr);
          ci_nxt    = q_t'(bus.in_ci);
          zr_nxt    = '0;
          zi_nxt    = '0;
          cnt_nxt   = '0;
`ifdef MANDEL_PERIOD_CHECK_EN
          sr_nxt    = '0;
          si_nxt    = '0;
          sv_nxt    = 1'b0;
`endif
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (size) begin
          // escape wins over the limit; z is left as it was
          iter_nxt  = cnt;
          esc_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          zr_nxt  = step_zr;
          zi_nxt  = step_zi;
          cnt_nxt = cnt_inc[ITER_W-1:0];
`ifdef MANDEL_PERIOD_CHECK_EN
          // compare against the old snapshot before reloading it
          if (snap) begin
            sr_nxt = step_zr;
            si_nxt = step_zi;
            sv_nxt = 1'b1;
          end
          if (per_hit) begin
            iter_nxt  = MAX_O;
            esc_nxt   = 1'b0;
            per_nxt   = 1'b1;
            state_nxt = DONE;
          end else
`endif
          if (last) begin
            iter_nxt  = MAX_O;
            esc_nxt   = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          iter_nxt  = '0;
          esc_nxt   = 1'b0;
`ifdef MANDEL_PERIOD_CHECK_EN
          per_nxt   = 1'b0;
`endif
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      iter_nxt  = '0;
      esc_nxt   = 1'b0;
`ifdef MANDEL_PERIOD_CHECK_EN
      per_nxt   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cr     <= '0;
      ci     <= '0;
      zr     <= '0;
      zi     <= '0;
      cnt    <= '0;
      iter_q <= '0;
      esc_q  <= 1'b0;
`ifdef MANDEL_PERIOD_CHECK_EN
      sr     <= '0;
      si     <= '0;
      sv     <= 1'b0;
      per_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cr     <= cr_nxt;
      ci     <= ci_nxt;
      zr     <= zr_nxt;
      zi     <= zi_nxt;
      cnt    <= cnt_nxt;
      iter_q <= iter_nxt;
      esc_q  <= esc_nxt;
`ifdef MANDEL_PERIOD_CHECK_EN
      sr     <= sr_nxt;
      si     <= si_nxt;
      sv     <= sv_nxt;
      per_q  <= per_nxt;
`endif
    end
  end

  assign bus.in_ready    = state == IDLE;
  assign bus.out_valid   = state == DONE;
  assign bus.out_iter    = iter_q;
  assign bus.out_escaped = esc_q;
`ifdef MANDEL_PERIOD_CHECK_EN
  assign bus.out_periodic = per_q;
`else
  assign bus.out_periodic = 1'b0;
`endif

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// tb_mandelbrot_iter_ctrl: directed vectors for the Mandelbrot iteration engine.
// Table of hand-computed Q2.8 results plus hold, abort and reset sequences.
module tb_mandelbrot_iter_ctrl;

  localparam int W    = 10;
  localparam int IW   = 8;
  localparam int MAXI = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic abort = 1'b0;

  mandelbrot_if #(.WIDTH(W), .ITER_W(IW)) bus ();

  mandelbrot_iter_ctrl #(
    .WIDTH   (W),
    .ITER_W  (IW),
    .MAX_ITER(MAXI)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .abort(abort),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cr;
    int ci;
    int iter;
    int esc;
    int per;
    int lat;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // called #1 after an edge with the engine idle; returns after accept edge
  task automatic launch(input int cr, input int ci);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_cr    = W'(cr);
    bus.in_ci    = W'(ci);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // edges after accept until out_valid; 1000 means it never came
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
  endtask

  task automatic chk_result(input string tag, input vec_t v, input int lat);
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_iter"}, int'(bus.out_iter), v.iter);
    chk({tag, "_esc"}, int'(bus.out_escaped), v.esc);
    chk({tag, "_per"}, int'(bus.out_periodic), v.per);
  endtask

  initial begin
    int   lat;
    vec_t v;

    // Q2.8: 256 = 1.0, -512 = -2.0
`ifdef MANDEL_PERIOD_CHECK_EN
    vecs[0] = '{0, 0, 255, 0, 1, 2};
    vecs[4] = '{0, -512, 255, 0, 1, 2};
`else
    vecs[0] = '{0, 0, 255, 0, 0, 255};
    vecs[4] = '{0, -512, 255, 0, 0, 255};
`endif
    vecs[1] = '{-512, -512, 1, 1, 0, 2};
    vecs[2] = '{0, 400, 2, 1, 0, 3};
    vecs[3] = '{200, 400, 3, 1, 0, 4};
    vecs[5] = '{511, 511, 1, 1, 0, 2};

    bus.in_valid  = 1'b0;
    bus.in_cr     = '0;
    bus.in_ci     = '0;
    bus.out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_iter", int'(bus.out_iter), 0);
    chk("rst_out_esc", int'(bus.out_escaped), 0);
    chk("rst_out_per", int'(bus.out_periodic), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].cr, vecs[i].ci);
      wait_done(lat);
      chk_result($sformatf("vec%0d", i), vecs[i], lat);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_handoff", i), int'(bus.out_valid), 0);
    end

    // consumer stalls: result must hold, input side stays closed
    bus.out_ready = 1'b0;
    launch(0, 400);
    wait_done(lat);
    chk_result("hold", vecs[2], lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_iter", int'(bus.out_iter), 2);
      chk("hold_esc", int'(bus.out_escaped), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_valid", int'(bus.out_valid), 0);
    chk("hold_release_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    chk("hold_single_result", int'(bus.out_valid), 0);

    // abort in the sixth ITER cycle
    launch(0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("abort_pre_valid", int'(bus.out_valid), 0);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_out_iter", int'(bus.out_iter), 0);
    launch(200, 400);
    wait_done(lat);
    chk_result("after_abort", vecs[3], lat);
    @(posedge clk);
    #1;

    // async reset between edges mid-ITER
    launch(0, 0);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_in_ready", int'(bus.in_ready), 1);
    chk("arst_out_iter", int'(bus.out_iter), 0);
    chk("arst_out_esc", int'(bus.out_escaped), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_release_in_ready", int'(bus.in_ready), 1);
    v = vecs[1];
    launch(v.cr, v.ci);
    wait_done(lat);
    chk_result("after_reset", v, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
